// File: rtl/perf_monitor.sv
// perf_monitor: per-channel event counters with a run-length cycle counter.
//
// A run starts from IDLE on start_i. In RUN the cycle counter and the event
// counters advance; the run ends in DONE once cycle_o reaches limit_i
// (limit_i == 0 means unlimited). Counters saturate at all-ones; a channel
// event that hits a saturated counter sets that channel's sticky sat flag.
// snap_i copies the live counters into shadow registers, and sel_i picks
// which shadow appears on the registered count_o.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    begin a run (honoured only in IDLE)
//   clear_i    zero counters, shadows and flags; return to IDLE
//   event_i    per-channel event pulses, one count per high cycle in RUN
//   limit_i    run length in cycles (0 = unlimited)
//   snap_i     capture the live counters into the shadows
//   sel_i      shadow channel to present on count_o (>= NUM_CH gives 0)
//   count_o    registered shadow value for sel_i
//   cycle_o    live cycle counter
//   running_o  high in RUN
//   done_o     high in DONE
//   sat_o      sticky per-channel saturation flags
module perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic              snap_i,
  input  logic [2:0]        sel_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              running_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] sat_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [NUM_CH-1:0] sat_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  sel_val;
  logic              last_cycle;

  // The edge on which the counter moves from limit-1 to limit ends the run.
  assign last_cycle = (limit_i != '0) && (cycle_q == limit_i - CNT_W'(1));

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last_cycle) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    sel_val = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (sel_i == 3'(ch)) sel_val = shadow_q[ch];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cycle_q <= '0;
      sat_q   <= '0;
      count_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch]    <= '0;
        shadow_q[ch] <= '0;
      end
    end else begin
      if (state_q == RUN && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (state_q == RUN && event_i[ch]) begin
          if (cnt_q[ch] == '1) sat_q[ch] <= 1'b1;
          else                 cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
        end
        // Non-blocking read of cnt_q gives the pre-update value of this edge.
        if (snap_i) shadow_q[ch] <= cnt_q[ch];
      end
      count_q <= sel_val;
    end
  end

  assign count_o   = count_q;
  assign cycle_o   = cycle_q;
  assign sat_o     = sat_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default instance (NUM_CH=4, CNT_W=32)
// and a narrow instance (CNT_W=4) sharing control inputs.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clear, snap;
  logic [3:0]  ev;
  logic [31:0] limit;
  logic [3:0]  limit_s;
  logic [2:0]  sel;

  logic [31:0] count, cycle;
  logic        running, done;
  logic [3:0]  sat;

  logic [3:0]  count_s, cycle_s;
  logic        running_s, done_s;
  logic [3:0]  sat_s;

  int errors = 0;
  int checks = 0;
  logic done_seen;

  always #5 clk = ~clk;

  perf_monitor #(.NUM_CH(4), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .event_i(ev), .limit_i(limit), .snap_i(snap), .sel_i(sel),
    .count_o(count), .cycle_o(cycle), .running_o(running),
    .done_o(done), .sat_o(sat)
  );

  perf_monitor #(.NUM_CH(4), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .event_i(ev), .limit_i(limit_s), .snap_i(snap), .sel_i(sel),
    .count_o(count_s), .cycle_o(cycle_s), .running_o(running_s),
    .done_o(done_s), .sat_o(sat_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0;
    ev = '0; limit = '0; limit_s = '0; sel = '0;
    step(); step();
    rst = 1'b0;
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cycle", cycle, 0);
    check("rst_count", count, 0);
    check("rst_sat", sat, 0);

    // Basic run: limit 10, channel 0 active every cycle.
    limit = 32'd10; ev = 4'b0001; start = 1'b1;
    step();
    start = 1'b0;
    check("s1_enter_run", running, 1);
    check("s1_cycle_start", cycle, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i < 10) check("s1_running", running, 1);
    end
    check("s1_done", done, 1);
    check("s1_not_running", running, 0);
    check("s1_cycle_eq_limit", cycle, 10);
    snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd0;
    step();
    check("s1_ch0_count", count, 10);

    // Out-of-range select.
    sel = 3'd6;
    step();
    check("s6_sel6_zero", count, 0);
    sel = 3'd0;
    step();
    check("s6_sel0_again", count, 10);

    // start in DONE is ignored; cycle holds.
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_ignored", done, 1);
    check("done_cycle_hold", cycle, 10);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_done", done, 0);
    check("clr_cycle", cycle, 0);
    check("clr_count", count, 0);

    // Saturation on the 4-bit instance, unlimited run, channel 1.
    limit = '0; limit_s = '0; ev = 4'b0010; start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    check("s2_sat_before", sat_s, 4'b0000);
    step();
    check("s2_sat_16th", sat_s, 4'b0010);
    repeat (4) step();
    snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd1;
    step();
    check("s2_count_sat", count_s, 15);
    check("s2_sat_sticky", sat_s, 4'b0010);
    check("s2_cycle_sat", cycle_s, 15);
    check("s2_still_running", running_s, 1);
    check("s2_wide_count", count, 20);
    check("s2_wide_no_sat", sat, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("s2_clr_sat", sat_s, 0);
    check("s2_clr_count", count_s, 0);

    // Snapshot mid-run on channel 2.
    ev = 4'b0100; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd2;
    step();
    check("s3_snap5", count, 5);
    check("s3_cycle", cycle, 7);
    snap = 1'b1;
    step();
    snap = 1'b0;
    step();
    check("s3_snap_later", count, 7);

    // Clear together with start, snap and all events while running.
    clear = 1'b1; start = 1'b1; snap = 1'b1; ev = 4'hF;
    step();
    clear = 1'b0; start = 1'b0; snap = 1'b0; ev = 4'h0;
    check("s4_running", running, 0);
    check("s4_done", done, 0);
    check("s4_cycle", cycle, 0);
    check("s4_sat", sat, 0);
    check("s4_count", count, 0);
    step();
    check("s4_shadow_zero", count, 0);
    check("s4_stays_idle", running, 0);

    // Reset mid-run.
    done_seen = 1'b0;
    limit = 32'd20; ev = 4'b0001; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) begin
      step();
      done_seen |= done;
    end
    check("s5_cycle7", cycle, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s5_running", running, 0);
    check("s5_done", done, 0);
    check("s5_cycle", cycle, 0);
    check("s5_count", count, 0);
    repeat (25) begin
      step();
      done_seen |= done;
    end
    check("s5_done_never", done_seen, 0);
    check("s5_cycle_hold", cycle, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of event channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of each event counter and of the cycle counter.
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i  input  1  begins a measurement run when sampled high in IDLE.
REQ-006 The block SHALL have port clear_i  input  1  zeroes all counters and sticky flags, then returns the block to IDLE.
REQ-007 The block SHALL have port event_i  input  NUM_CH  per-channel event pulses (stall, flush, etc.), one count per high cycle.
REQ-008 The block SHALL have port limit_i  input  CNT_W  run length in cycles; 0 means unlimited.
REQ-009 The block SHALL have port snap_i  input  1  copies all live counters into shadow registers.
REQ-010 The block SHALL have port sel_i  input  3  selects the shadow channel driven on count_o.
REQ-011 The block SHALL have port count_o  output  CNT_W  registered shadow value of channel sel_i.
REQ-012 The block SHALL have port cycle_o  output  CNT_W  live cycle counter.
REQ-013 The block SHALL have port running_o  output  1  high while in RUN.
REQ-014 The block SHALL have port done_o  output  1  high while in DONE; also serves as the halt request to the bench.
REQ-015 The block SHALL have port sat_o  output  NUM_CH  per-channel sticky saturation flags.

Function
REQ-016 The state machine SHALL have states IDLE, RUN and DONE.
REQ-017 Transitions SHALL be: IDLE->RUN on start_i; RUN->DONE when limit_i!=0 and the cycle counter holds limit_i-1 at the edge; DONE->IDLE on clear_i; any state->IDLE on clear_i.
REQ-018 In RUN, the cycle counter SHALL increment by 1 on every edge; it SHALL hold in IDLE and DONE.
REQ-019 In RUN, each channel counter SHALL increment by 1 on each edge where event_i[ch]=1; events outside RUN SHALL be ignored.
REQ-020 Events on the edge that takes IDLE->RUN SHALL NOT be counted; events on the edge that takes RUN->DONE SHALL be counted.
REQ-021 On reaching DONE, cycle_o SHALL equal limit_i exactly.
REQ-022 A counter at all-ones SHALL saturate; no wrap. A further event SHALL set sat_o[ch], which stays set until clear_i or rst_i.
REQ-023 The cycle counter SHALL saturate at all-ones in unlimited mode without setting any flag.
REQ-024 snap_i SHALL capture the pre-update counter values of the same edge into the shadow registers, in any state.
REQ-025 count_o SHALL equal the shadow value for sel_i one cycle after sel_i is sampled; sel_i>=NUM_CH SHALL yield 0.
REQ-026 clear_i SHALL zero the live counters, shadows, cycle counter and sat_o, and SHALL take priority over start_i, snap_i and event_i on the same edge.
REQ-027 start_i in RUN or DONE SHALL be ignored.
REQ-028 limit_i SHALL be sampled every cycle; lowering it below the current cycle_o+1 mid-run SHALL leave the run in RUN until the cycle counter saturates (no retroactive stop).

Reset
REQ-029 rst_i SHALL override every other input, including mid-run.
REQ-030 On rst_i, the block SHALL enter IDLE and all counters, shadows, count_o, cycle_o and sat_o SHALL be set to 0.
REQ-031 On rst_i, running_o and done_o SHALL be set to 0 on the following edge.

Verification
REQ-032 Scenario 1, basic run: NUM_CH=4, limit_i=10, start_i for 1 cycle, event_i[0] high every cycle -> running_o high for 10 cycles, then done_o=1, cycle_o=10, channel 0 count=10.
REQ-033 Scenario 2, saturation: CNT_W=4, limit_i=0, event_i[1] held high for 20 run cycles -> channel 1 count=15, sat_o[1]=1 from the 16th event, sat_o of other channels=0.
REQ-034 Scenario 3, snapshot: snap_i at cycle 5 of a run with event_i[2] always high, then sel_i=2 -> count_o=5 one cycle later, while the live count continues to increase.
REQ-035 Scenario 4, simultaneous clear: clear_i, start_i and event_i=4'hF on the same edge in RUN -> IDLE, all counts 0, sat_o=0.
REQ-036 Scenario 5, reset mid-run: rst_i at cycle 7 with limit_i=20 -> next edge IDLE, cycle_o=0, done_o never asserted.
REQ-037 Scenario 6, out-of-range select: NUM_CH=4, sel_i=6 -> count_o=0.
